// File: rtl/effect_fade_ctrl_if.sv
// Sample-stream bundle between the codec side, the fade controller and one effect unit.
// The controller takes the slave modport; the upstream/effect side takes master.
interface effect_fade_ctrl_if;
  logic signed [23:0] in_data;
  logic               wren;
  logic               on;
  logic signed [23:0] fx_data;
  logic               fx_wren;
  logic               fx_on;
  logic signed [23:0] fx_out;
  logic               fx_valid;
  logic signed [23:0] out_data;
  logic               out_valid;
  logic               fading;
  logic               overrun;

  modport master (
    output in_data, wren, on, fx_out, fx_valid,
    input  fx_data, fx_wren, fx_on, out_data, out_valid, fading, overrun
  );

  modport slave (
    input  in_data, wren, on, fx_out, fx_valid,
    output fx_data, fx_wren, fx_on, out_data, out_valid, fading, overrun
  );
endinterface

// File: rtl/effect_fade_ctrl.sv
// Click-free enable controller: linear dry/wet crossfade over 2^FADE_SHIFT samples
// whenever the effect is switched on or off.
module effect_fade_ctrl #(
  parameter int FADE_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  effect_fade_ctrl_if.slave  bus
);
  localparam int N  = 1 << FADE_SHIFT;
  localparam int GW = FADE_SHIFT + 1;
  localparam int MW = 24 + FADE_SHIFT + 2;
  localparam logic [GW-1:0] G_N    = GW'(N);
  localparam logic [GW-1:0] G_ONE  = GW'(1);
  localparam logic [GW-1:0] G_ZERO = '0;

  typedef enum logic [1:0] {DRY, FADE_IN, WET, FADE_OUT} state_e;

  state_e             state_q, state_d;
  logic [GW-1:0]      g_q, g_d, g_inc, g_dec;
  logic signed [23:0] dry_q, out_data_q, mix_out;
  logic               pending_q, out_valid_q, overrun_q, fx_on_q, fading_q;
  logic               mix_ev;
  logic signed [MW-1:0] dry_s, wet_s, g_s, ng_s, mix_sum;

  assign bus.fx_data   = bus.in_data;
  assign bus.fx_wren   = bus.wren;
  assign bus.fx_on     = fx_on_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.fading    = fading_q;
  assign bus.overrun   = overrun_q;

  assign mix_ev = bus.fx_valid & pending_q;
  assign g_inc  = g_q + G_ONE;
  assign g_dec  = g_q - G_ONE;

  // Weights are non-negative, so the gain zero-extends while samples sign-extend;
  // the arithmetic shift then rounds toward negative infinity.
  assign dry_s   = {{(MW-24){dry_q[23]}}, dry_q};
  assign wet_s   = {{(MW-24){bus.fx_out[23]}}, bus.fx_out};
  assign g_s     = {{(MW-GW){1'b0}}, g_q};
  assign ng_s    = MW'(N) - g_s;
  assign mix_sum = dry_s * ng_s + wet_s * g_s;
  assign mix_out = 24'(mix_sum >>> FADE_SHIFT);

  // NOTE: every output of a combinational block gets a default first, otherwise
  // any path that skips an assignment infers a latch.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    case (state_q)
      DRY: begin
        if (bus.on) begin
          state_d = FADE_IN;
          g_d     = G_ONE;
        end
      end
      FADE_IN, FADE_OUT: begin
        if (bus.on) begin
          g_d     = g_inc;
          state_d = (g_inc == G_N) ? WET : FADE_IN;
        end else begin
          g_d     = g_dec;
          state_d = (g_dec == G_ZERO) ? DRY : FADE_OUT;
        end
      end
      WET: begin
        if (!bus.on) begin
          state_d = FADE_OUT;
          g_d     = G_N - G_ONE;
        end
      end
      default: begin
        state_d = DRY;
        g_d     = G_ZERO;
      end
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DRY;
      g_q         <= G_ZERO;
      dry_q       <= '0;
      pending_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      fx_on_q     <= 1'b0;
      fading_q    <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (mix_ev) begin
        out_data_q  <= mix_out;
        out_valid_q <= 1'b1;
        pending_q   <= 1'b0;
        state_q     <= state_d;
        g_q         <= g_d;
        fx_on_q     <= (state_d != DRY);
        fading_q    <= (state_d == FADE_IN) || (state_d == FADE_OUT);
      end else if (bus.wren && pending_q) begin
        // Effect never answered: flush the stale sample dry, keep the fade position.
        out_data_q  <= dry_q;
        out_valid_q <= 1'b1;
        overrun_q   <= 1'b1;
      end
      // Capture last so a same-cycle mix consumes the old sample before re-arming.
      if (bus.wren) begin
        dry_q     <= bus.in_data;
        pending_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_effect_fade_ctrl.sv
// Self-checking bench for effect_fade_ctrl with FADE_SHIFT=2 (N=4): vector table
// plus hand-written overrun, same-cycle, stray-strobe and mid-fade reset sequences.
module tb_effect_fade_ctrl;
  localparam int FS = 2;

  logic clk = 1'b0;
  logic reset;

  effect_fade_ctrl_if bus ();

  effect_fade_ctrl #(.FADE_SHIFT(FS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [23:0] data;
    logic               fx_on;
    logic               fading;
    logic               overrun;
  } exp_t;

  typedef struct {
    logic signed [23:0] dry;
    logic signed [23:0] wet;
    logic               on;
    logic               valid;
    logic signed [23:0] exp_data;
    logic               exp_fx_on;
    logic               exp_fading;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic signed [23:0] data, input logic fx_on,
                          input logic fading, input logic ovr);
    exp_t e;
    e.data = data; e.fx_on = fx_on; e.fading = fading; e.overrun = ovr;
    exp_q.push_back(e);
  endtask

  task automatic add_vec(input logic signed [23:0] dry, input logic signed [23:0] wet,
                         input logic on_v, input logic signed [23:0] exp_data,
                         input logic exp_fx_on, input logic exp_fading);
    vec_t v;
    v.dry = dry; v.wet = wet; v.on = on_v; v.valid = 1'b1;
    v.exp_data = exp_data; v.exp_fx_on = exp_fx_on; v.exp_fading = exp_fading;
    vecs.push_back(v);
  endtask

  // One sample: wren, effect answer one cycle later (if valid), output due the cycle after.
  task automatic drive_sample(input logic signed [23:0] dry, input logic signed [23:0] wet,
                              input logic on_v, input logic valid);
    @(negedge clk);
    bus.in_data = dry;
    bus.wren    = 1'b1;
    bus.on      = on_v;
    #1;
    check("fx_wren_pass", bus.fx_wren, 1'b1);
    check("fx_data_pass", bus.fx_data, dry);
    @(negedge clk);
    bus.wren     = 1'b0;
    bus.fx_valid = valid;
    bus.fx_out   = wet;
    @(negedge clk);
    bus.fx_valid = 1'b0;
    #1;
    check("outputs_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_data"},  bus.out_data,  0);
    check({tag, "_out_valid"}, bus.out_valid, 1'b0);
    check({tag, "_overrun"},   bus.overrun,   1'b0);
    check({tag, "_fx_on"},     bus.fx_on,     1'b0);
    check({tag, "_fading"},    bus.fading,    1'b0);
  endtask

  // Scoreboard: every out_valid must match the oldest expected result.
  always @(negedge clk) begin
    if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got data %0d with nothing expected", bus.out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("fx_on",    bus.fx_on,    e.fx_on);
        check("fading",   bus.fading,   e.fading);
        check("overrun",  bus.overrun,  e.overrun);
      end
    end else if (bus.overrun) begin
      check("overrun_without_valid", bus.overrun, 1'b0);
    end
  end

  initial begin
    bus.in_data  = '0;
    bus.wren     = 1'b0;
    bus.on       = 1'b0;
    bus.fx_out   = '0;
    bus.fx_valid = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Fade-in, wet steady, fade-out, mid-fade reversal (dry=1000, wet=2000).
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: add_vec(24'sd1000, 24'sd2000, 1'b1, 24'sd1000, 1'b1, 1'b1);
        1: add_vec(24'sd1000, 24'sd2000, 1'b1, 24'sd1250, 1'b1, 1'b1);
        2: add_vec(24'sd1000, 24'sd2000, 1'b1, 24'sd1500, 1'b1, 1'b1);
        3: add_vec(24'sd1000, 24'sd2000, 1'b1, 24'sd1750, 1'b1, 1'b0);
        default: add_vec(24'sd1000, 24'sd2000, 1'b1, 24'sd2000, 1'b1, 1'b0);
      endcase
    end
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd2000, 1'b1, 1'b1);
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd1750, 1'b1, 1'b1);
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd1500, 1'b1, 1'b1);
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd1250, 1'b0, 1'b0);
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd1000, 1'b0, 1'b0);
    add_vec(24'sd1000, 24'sd2000, 1'b1, 24'sd1000, 1'b1, 1'b1);
    add_vec(24'sd1000, 24'sd2000, 1'b1, 24'sd1250, 1'b1, 1'b1);
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd1500, 1'b1, 1'b1);
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd1250, 1'b0, 1'b0);
    add_vec(24'sd1000, 24'sd2000, 1'b0, 24'sd1000, 1'b0, 1'b0);
    // Signed rounding at g=1: each on=1 sample moves DRY->g=1, the next mixes and returns.
    add_vec(24'sd5,        24'sd9,          1'b1, 24'sd5,        1'b1, 1'b1);
    add_vec(-24'sd400,     24'sd400,        1'b0, -24'sd200,     1'b0, 1'b0);
    add_vec(24'sd7,        24'sd0,          1'b1, 24'sd7,        1'b1, 1'b1);
    add_vec(-24'sd1,       24'sd0,          1'b0, -24'sd1,       1'b0, 1'b0);
    add_vec(24'sd0,        24'sd0,          1'b1, 24'sd0,        1'b1, 1'b1);
    add_vec(24'sh7FFFFF,   24'sh800000,     1'b0, 24'sh3FFFFF,   1'b0, 1'b0);

    foreach (vecs[i]) begin
      if (vecs[i].valid) push_exp(vecs[i].exp_data, vecs[i].exp_fx_on, vecs[i].exp_fading, 1'b0);
      drive_sample(vecs[i].dry, vecs[i].wet, vecs[i].on, vecs[i].valid);
    end

    // Overrun at g=1: stale 500 flushed dry, then 600 mixes still at g=1 -> 950.
    push_exp(24'sd1000, 1'b1, 1'b1, 1'b0);
    drive_sample(24'sd1000, 24'sd2000, 1'b1, 1'b1);
    drive_sample(24'sd500, 24'sd2000, 1'b1, 1'b0);
    push_exp(24'sd500, 1'b1, 1'b1, 1'b1);
    push_exp(24'sd950, 1'b1, 1'b1, 1'b0);
    drive_sample(24'sd600, 24'sd2000, 1'b1, 1'b1);

    // Late answer coinciding with the next wren: mix first (g=2), no overrun.
    push_exp(24'sd1350, 1'b1, 1'b1, 1'b0);
    push_exp(24'sd1700, 1'b1, 1'b0, 1'b0);
    @(negedge clk); bus.in_data = 24'sd700; bus.wren = 1'b1; bus.on = 1'b1;
    @(negedge clk); bus.wren = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.in_data = 24'sd800; bus.wren = 1'b1;
    bus.fx_valid = 1'b1; bus.fx_out = 24'sd2000;
    @(negedge clk); bus.wren = 1'b0;
    @(negedge clk); bus.fx_valid = 1'b0;
    #1;
    check("same_cycle_drained", exp_q.size(), 0);

    // Stray effect strobe with nothing pending: no output, state stays WET.
    @(negedge clk); bus.fx_valid = 1'b1; bus.fx_out = 24'sd999;
    @(negedge clk); bus.fx_valid = 1'b0;
    @(negedge clk);
    push_exp(24'sd3000, 1'b1, 1'b0, 1'b0);
    drive_sample(24'sd100, 24'sd3000, 1'b1, 1'b1);

    // Reset mid fade-in at g=2, then a pure dry sample.
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    push_exp(24'sd1000, 1'b1, 1'b1, 1'b0);
    drive_sample(24'sd1000, 24'sd2000, 1'b1, 1'b1);
    push_exp(24'sd1250, 1'b1, 1'b1, 1'b0);
    drive_sample(24'sd1000, 24'sd2000, 1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outputs("midfade_reset");
    push_exp(24'sd1234, 1'b0, 1'b0, 1'b0);
    drive_sample(24'sd1234, 24'sd2000, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("final_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
